// File: rtl/err_watchdog_if.sv
// Monitor bus between the processor under test and err_watchdog.
// master = processor side (drives events), slave = watchdog side (drives status).
interface err_watchdog_if #(
  parameter int unsigned NSRC  = 4,
  parameter int unsigned CNT_W = 32
) ();

  logic [NSRC-1:0]  err_src;
  logic             commit;
  logic             halt;
  logic             err;
  logic             halted;
  logic [CNT_W-1:0] cyc_cnt;
  logic [NSRC+1:0]  err_cause;
  logic [CNT_W-1:0] err_cycle;

  modport master (
    output err_src, commit, halt,
    input  err, halted, cyc_cnt, err_cause, err_cycle
  );

  modport slave (
    input  err_src, commit, halt,
    output err, halted, cyc_cnt, err_cause, err_cycle
  );

endinterface

// File: rtl/err_watchdog.sv
// Sticky error / liveness monitor for the processor under test; drives err to the clk/rst generator.
// Optional fault-cause capture and report enabled by defining ERR_WATCHDOG_CAUSE_EN.
module err_watchdog #(
  parameter int unsigned NSRC    = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input  logic          clk,
  input  logic          rst,
  err_watchdog_if.slave bus
);

  localparam int unsigned CW = NSRC + 2;
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic             err_q;
  logic             halted_q;

  logic src_hit;
  logic wdog_hit;
  logic run_fault;
  logic halt_fault;

  // Fault conditions evaluated against the current state; shared with cause capture.
  assign src_hit    = |bus.err_src;
  assign wdog_hit   = !bus.commit && (idle_cnt == IDLE_LIMIT);
  assign run_fault  = (state == RUN) && (src_hit || wdog_hit);
  assign halt_fault = (state == HALT) && bus.commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      idle_cnt <= '0;
      cyc_cnt  <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      if (cyc_cnt != CNT_MAX) begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
      end
      case (state)
        RUN: begin
          // A commit on the last allowed idle cycle clears the counter and averts the fault.
          idle_cnt <= bus.commit ? '0 : idle_cnt + CNT_W'(1);
          if (run_fault) begin
            state <= FAULT;
            err_q <= 1'b1;
          end else if (bus.halt) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT: begin
          if (halt_fault) begin
            state    <= FAULT;
            err_q    <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        FAULT: begin
        end
        default: begin
          state    <= FAULT;
          err_q    <= 1'b1;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.err     = err_q;
  assign bus.halted  = halted_q;
  assign bus.cyc_cnt = cyc_cnt;

`ifdef ERR_WATCHDOG_CAUSE_EN
  logic [CW-1:0]    cause_q;
  logic [CNT_W-1:0] cycle_q;

  // Snapshot taken on the edge that enters FAULT; cyc_cnt is the faulting cycle's index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= '0;
      cycle_q <= '0;
    end else if (run_fault) begin
      cause_q <= {1'b0, wdog_hit, bus.err_src};
      cycle_q <= cyc_cnt;
      $display("err_watchdog: fault cause=%b cycle=%0d", {1'b0, wdog_hit, bus.err_src}, cyc_cnt);
    end else if (halt_fault) begin
      cause_q <= {2'b10, {NSRC{1'b0}}};
      cycle_q <= cyc_cnt;
      $display("err_watchdog: fault cause=%b cycle=%0d", {2'b10, {NSRC{1'b0}}}, cyc_cnt);
    end
  end

  assign bus.err_cause = cause_q;
  assign bus.err_cycle = cycle_q;
`else
  assign bus.err_cause = {CW{1'b0}};
  assign bus.err_cycle = {CNT_W{1'b0}};
`endif

endmodule
